stopwatch_ctrl: RTL

Run-control sequencer for the stopwatch counter/FND datapath. It converts the Start, Stop and Lap button pulses into a four-state run FSM. It generates the counter's count-enable tick from a programmable prescaler, a one-cycle clear pulse, and a display-hold flag for lap freeze. It sits between the debounced button inputs and the stopwatch counter and FND scan logic.

---
 rtl/stopwatch_ctrl_if.sv | 33 +++
 rtl/stopwatch_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button-request and run-control signal bundle between the debounced
// buttons / counter datapath (master side) and the stopwatch sequencer (slave side).
interface stopwatch_ctrl_if;
  logic       i_fStart;
  logic       i_fStop;
  logic       i_fLap;
  logic       o_Tick;
  logic       o_Clr;
  logic       o_Hold;
  logic [1:0] o_State;

  // Sequencer side: consumes button requests, produces run-control outputs.
  modport slave (
    input  i_fStart,
    input  i_fStop,
    input  i_fLap,
    output o_Tick,
    output o_Clr,
    output o_Hold,
    output o_State
  );

  // Environment side: drives button requests, observes run-control outputs.
  modport master (
    output i_fStart,
    output i_fStop,
    output i_fLap,
    input  o_Tick,
    input  o_Clr,
    input  o_Hold,
    input  o_State
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: edge-detects the Start/Stop/Lap buttons,
// runs the IDLE/RUN/PAUSE/LAP state machine, and generates the counter's
// count-enable tick, clear pulse and display-hold flag.
module stopwatch_ctrl #(
  parameter int P_TICK_DIV = 500000
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  stopwatch_ctrl_if.slave    bus
);

  localparam int W = $clog2(P_TICK_DIV);
  localparam logic [W-1:0] LAST = W'(P_TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           startPrev_q, stopPrev_q, lapPrev_q;
  logic           hold_q, clr_q;
  logic [W-1:0]   presc_q, presc_d;
  logic           tick_q, tick_d;

  logic           startRise, stopRise, lapRise;
  logic           stopEv, startEv, lapEv;
  logic           counting;

  // A button acts once per rising edge; Stop outranks Start, which outranks Lap.
  assign startRise = bus.i_fStart & ~startPrev_q;
  assign stopRise  = bus.i_fStop  & ~stopPrev_q;
  assign lapRise   = bus.i_fLap   & ~lapPrev_q;
  assign stopEv    = stopRise;
  assign startEv   = startRise & ~stopRise;
  assign lapEv     = lapRise & ~stopRise & ~startRise;

  // The prescaler advances only while the registered state is a running one.
  assign counting  = (state_q == RUN) || (state_q == LAP);

  // Previous-sample registers for the button edge detectors.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      startPrev_q <= 1'b0;
      stopPrev_q  <= 1'b0;
      lapPrev_q   <= 1'b0;
    end else begin
      startPrev_q <= bus.i_fStart;
      stopPrev_q  <= bus.i_fStop;
      lapPrev_q   <= bus.i_fLap;
    end
  end

  // State register, with hold flag and clear pulse registered alongside it.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= (state_d == LAP);
      clr_q   <= stopEv;
    end
  end

  // Next-state logic; events not meaningful in the current state are ignored.
  always_comb begin
    state_d = state_q;
    if (stopEv) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (startEv) state_d = RUN;
        RUN:     if (startEv) state_d = PAUSE;
                 else if (lapEv) state_d = LAP;
        LAP:     if (startEv) state_d = PAUSE;
                 else if (lapEv) state_d = RUN;
        PAUSE:   if (startEv) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Prescaler: cleared by Stop or IDLE, frozen in PAUSE so a resumed run keeps
  // its partial period, and wrapping with a tick at the last count.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (stopEv || (state_q == IDLE)) begin
      presc_d = '0;
    end else if (counting) begin
      if (presc_q == LAST) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + W'(1);
      end
    end
  end

  // Prescaler and tick registers.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.o_State = state_q;
  assign bus.o_Hold  = hold_q;
  assign bus.o_Clr   = clr_q;
  assign bus.o_Tick  = tick_q;

endmodule
